// File: rtl/cgra_conf_loader.sv
`default_nettype none
// ============================================================================
// cgra_conf_loader : assembles 5-word PE configurations and strobes each PE
// Revision : 1.0
// ============================================================================
module cgra_conf_loader #(
   parameter int NUM_PES      = 16,
   parameter int WORDS_PER_PE = 5,
   localparam int IDX_W       = (NUM_PES > 1) ? $clog2(NUM_PES) : 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [31:0]        din_i,
   input  logic               din_v_i,
   output logic               din_r_o,
   output logic [143:0]       conf_bits_o,
   output logic [5:0]         eb_enables_o,
   output logic [NUM_PES-1:0] conf_en_o,
   output logic               busy_o,
   output logic               done_o,
   output logic [IDX_W-1:0]   pe_idx_o
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam logic [2:0]       LAST_WORD = 3'(WORDS_PER_PE - 1);
   localparam logic [IDX_W-1:0] LAST_PE   = IDX_W'(NUM_PES - 1);

   state_t           state;
   logic [2:0]       word_cnt;
   logic [IDX_W-1:0] pe_idx;
   logic [143:0]     conf_bits;
   logic [5:0]       eb_enables;
   logic             xfer;
   logic             unused_w4_hi;

   assign xfer         = din_v_i && (state == S_COLLECT);
   assign unused_w4_hi = ^din_i[31:22];

   // Handshake and status decode only from the registered state.
   assign din_r_o      = (state == S_COLLECT);
   assign busy_o       = (state != S_IDLE);
   assign done_o       = (state == S_DONE);
   assign conf_en_o    = (state == S_WRITE) ? (NUM_PES'(1) << pe_idx) : '0;
   assign conf_bits_o  = conf_bits;
   assign eb_enables_o = eb_enables;
   assign pe_idx_o     = pe_idx;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state      <= S_IDLE;
         word_cnt   <= '0;
         pe_idx     <= '0;
         conf_bits  <= '0;
         eb_enables <= '0;
      end else begin
         // A word accepted alongside abort still lands in its field register.
         if (xfer) begin
            case (word_cnt)
               3'd0:    conf_bits[31:0]   <= din_i;
               3'd1:    conf_bits[63:32]  <= din_i;
               3'd2:    conf_bits[95:64]  <= din_i;
               3'd3:    conf_bits[127:96] <= din_i;
               default: begin
                  conf_bits[143:128] <= din_i[15:0];
                  eb_enables         <= din_i[21:16];
               end
            endcase
         end

         if (abort_i) begin
            state    <= S_IDLE;
            word_cnt <= '0;
            pe_idx   <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start_i) begin
                     state    <= S_COLLECT;
                     word_cnt <= '0;
                     pe_idx   <= '0;
                  end
               end
               S_COLLECT: begin
                  if (xfer) begin
                     if (word_cnt == LAST_WORD) begin
                        state    <= S_WRITE;
                        word_cnt <= '0;
                     end else begin
                        word_cnt <= word_cnt + 3'd1;
                     end
                  end
               end
               S_WRITE: begin
                  if (pe_idx == LAST_PE) begin
                     state <= S_DONE;
                  end else begin
                     state    <= S_COLLECT;
                     pe_idx   <= pe_idx + IDX_W'(1);
                     word_cnt <= '0;
                  end
               end
               default: begin
                  state  <= S_IDLE;
                  pe_idx <= '0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cgra_conf_loader.sv
`default_nettype none
// ============================================================================
// tb_cgra_conf_loader : directed table-driven bench for cgra_conf_loader
// Revision : 1.0
// ============================================================================
module tb_cgra_conf_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Single-PE instance
   logic         a_rst_n, a_start, a_abort, a_din_v, a_din_r, a_busy, a_done;
   logic [31:0]  a_din;
   logic [143:0] a_bits;
   logic [5:0]   a_eb;
   logic [0:0]   a_en;
   logic [0:0]   a_idx;

   // Eight-PE instance
   logic         b_rst_n, b_start, b_abort, b_din_v, b_din_r, b_busy, b_done;
   logic [31:0]  b_din;
   logic [143:0] b_bits;
   logic [5:0]   b_eb;
   logic [7:0]   b_en;
   logic [2:0]   b_idx;

   cgra_conf_loader #(.NUM_PES(1), .WORDS_PER_PE(5)) dut_a (
      .clk_i(clk), .rst_ni(a_rst_n), .start_i(a_start), .abort_i(a_abort),
      .din_i(a_din), .din_v_i(a_din_v), .din_r_o(a_din_r),
      .conf_bits_o(a_bits), .eb_enables_o(a_eb), .conf_en_o(a_en),
      .busy_o(a_busy), .done_o(a_done), .pe_idx_o(a_idx)
   );

   cgra_conf_loader #(.NUM_PES(8), .WORDS_PER_PE(5)) dut_b (
      .clk_i(clk), .rst_ni(b_rst_n), .start_i(b_start), .abort_i(b_abort),
      .din_i(b_din), .din_v_i(b_din_v), .din_r_o(b_din_r),
      .conf_bits_o(b_bits), .eb_enables_o(b_eb), .conf_en_o(b_en),
      .busy_o(b_busy), .done_o(b_done), .pe_idx_o(b_idx)
   );

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic [4:0][31:0] w;
      int               gap_before;
      logic [143:0]     bits;
      logic [5:0]       eb;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word(input int p, input int k);
      if (k == 4) return {10'h3FF, 6'(p), 16'hC000 | 16'(p)};
      return 32'hA000_0000 | (32'(p) << 8) | 32'(k);
   endfunction

   function automatic logic [143:0] exp_bits(input int p);
      return {16'hC000 | 16'(p), word(p, 3), word(p, 2), word(p, 1), word(p, 0)};
   endfunction

   // One complete load on the 1-PE instance from a table record.
   task automatic run_a(input int v);
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      chk("a_din_r_collect", 160'(a_din_r), 160'(1));
      for (int k = 0; k < 5; k++) begin
         if (k == vecs[v].gap_before) begin
            a_din_v = 1'b0;
            tick();
            chk("a_no_strobe_gap", 160'(a_en), 160'(0));
         end
         a_din   = vecs[v].w[k];
         a_din_v = 1'b1;
         tick();
      end
      a_din_v = 1'b0;
      chk("a_conf_en", 160'(a_en), 160'(1));
      chk("a_conf_bits", 160'(a_bits), 160'(vecs[v].bits));
      chk("a_eb", 160'(a_eb), 160'(vecs[v].eb));
      chk("a_din_r_write", 160'(a_din_r), 160'(0));
      tick();
      chk("a_done", 160'(a_done), 160'(1));
      chk("a_en_after", 160'(a_en), 160'(0));
      chk("a_bits_held", 160'(a_bits), 160'(vecs[v].bits));
      tick();
      chk("a_busy_fall", 160'(a_busy), 160'(0));
      chk("a_done_fall", 160'(a_done), 160'(0));
   endtask

   // mode 0: full load, 1: start-while-busy then abort at PE stop_pe word 3,
   // 2: reset asserted during WRITE of PE stop_pe.
   task automatic run_b(input bit gaps, input int mode, input int stop_pe);
      int  tp = 0, tk = 0, strobes = 0, busy_cyc = 0, dones = 0;
      int  last_s = -100, done_c = -1, cyc = 0, extra = 0;
      bit  xfer, stop = 0, bad_r = 0;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      while (!stop && cyc < 600) begin
         if (!b_busy) begin
            stop = 1;
            break;
         end
         busy_cyc++;
         if (b_din_r && (b_en != 0 || b_done)) bad_r = 1;
         if (b_en != 0) begin
            chk("b_conf_en", 160'(b_en), 160'(8'd1 << strobes));
            chk("b_conf_bits", 160'(b_bits), 160'(exp_bits(strobes)));
            chk("b_eb", 160'(b_eb), 160'(6'(strobes)));
            if (!gaps) chk("b_strobe_time", 160'(cyc), 160'(5 + 6 * strobes));
            last_s = cyc;
            if (mode == 2 && strobes == stop_pe) begin
               b_rst_n = 1'b0;
               b_din_v = 1'b1;
               tick();
               b_rst_n = 1'b0;
               chk("rst_en", 160'(b_en), 160'(0));
               chk("rst_bits", 160'(b_bits), 160'(0));
               chk("rst_eb", 160'(b_eb), 160'(0));
               chk("rst_status", 160'({b_busy, b_done, b_din_r, b_idx}), 160'(0));
               b_rst_n = 1'b1;
               b_din_v = 1'b0;
               tick();
               return;
            end
            strobes++;
         end
         if (b_done) begin
            dones++;
            done_c = cyc;
         end
         if (mode == 1 && tp == stop_pe && tk == 3) begin
            b_start = 1'b1;
            b_din   = word(tp, tk);
            b_din_v = 1'b1;
            tick();
            b_start = 1'b0;
            chk("start_ignored_idx", 160'(b_idx), 160'(stop_pe));
            chk("start_ignored_busy", 160'(b_busy), 160'(1));
            b_din   = word(tp, 4);
            b_abort = 1'b1;
            tick();
            b_abort = 1'b0;
            chk("abort_busy", 160'(b_busy), 160'(0));
            chk("abort_en", 160'(b_en), 160'(0));
            chk("abort_din_r", 160'(b_din_r), 160'(0));
            chk("abort_idx", 160'(b_idx), 160'(0));
            b_start = 1'b1;
            b_abort = 1'b1;
            tick();
            b_start = 1'b0;
            b_abort = 1'b0;
            chk("abort_beats_start", 160'(b_busy), 160'(0));
            for (int i = 0; i < 10; i++) begin
               tick();
               if (b_en != 0 || b_done || b_busy) extra++;
            end
            chk("abort_quiet", 160'(extra), 160'(0));
            b_din_v = 1'b0;
            return;
         end
         b_din_v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         b_din   = word(tp, tk);
         xfer    = b_din_v && b_din_r;
         tick();
         cyc++;
         if (xfer) begin
            if (tk == 4) begin
               tk = 0;
               tp++;
            end else begin
               tk++;
            end
         end
      end
      b_din_v = 1'b0;
      chk("b_terminated", 160'(stop), 160'(1));
      chk("b_strobe_count", 160'(strobes), 160'(8));
      chk("b_done_count", 160'(dones), 160'(1));
      chk("b_done_after_last", 160'(done_c), 160'(last_s + 1));
      chk("b_din_r_illegal", 160'(bad_r), 160'(0));
      if (!gaps) chk("b_busy_cycles", 160'(busy_cyc), 160'(49));
   endtask

   initial begin
      vecs[0].w = {32'h003F_ABCD, 32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      vecs[0].gap_before = -1;
      vecs[0].bits = 144'hABCD_44444444_33333333_22222222_11111111;
      vecs[0].eb   = 6'h3F;
      vecs[1].w = {32'hFFC0_1234, 32'h0F0F_0F0F, 32'h89AB_CDEF, 32'h0123_4567, 32'hDEAD_BEEF};
      vecs[1].gap_before = -1;
      vecs[1].bits = 144'h1234_0F0F0F0F_89ABCDEF_01234567_DEADBEEF;
      vecs[1].eb   = 6'h00;
      vecs[2].w = {32'h0015_0000, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[2].gap_before = 2;
      vecs[2].bits = 144'h0000_5A5A5A5A_A5A5A5A5_FFFFFFFF_00000000;
      vecs[2].eb   = 6'h15;
      vecs[3].w = {32'hFFFF_FFFF, 32'h2468_ACE0, 32'h1357_9BDF, 32'h9ABC_DEF0, 32'h1234_5678};
      vecs[3].gap_before = 4;
      vecs[3].bits = 144'hFFFF_2468ACE0_13579BDF_9ABCDEF0_12345678;
      vecs[3].eb   = 6'h3F;

      a_rst_n = 1'b0; a_start = 1'b0; a_abort = 1'b0; a_din_v = 1'b0; a_din = '0;
      b_rst_n = 1'b0; b_start = 1'b0; b_abort = 1'b0; b_din_v = 1'b0; b_din = '0;
      tick();
      tick();
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;
      chk("reset_a", 160'({a_bits, a_eb, a_en, a_busy, a_done, a_din_r, a_idx}), 160'(0));
      chk("reset_b", 160'({b_bits, b_eb, b_en, b_busy, b_done, b_din_r, b_idx}), 160'(0));

      for (int v = 0; v < 4; v++) run_a(v);

      run_b(1'b0, 0, 0);
      run_b(1'b1, 0, 0);
      run_b(1'b0, 1, 2);
      run_b(1'b0, 0, 0);
      run_b(1'b0, 2, 5);
      run_b(1'b0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
